// File: rtl/bus_xfer_fabric_if.sv
// Handshake and data bundle between the control logic and the SAP bus fabric.
// The master modport is the requesting/sourcing side; the slave modport is the fabric.
interface bus_xfer_fabric_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 6,
    parameter int NDST  = 6
);
    localparam int SW = $clog2(NSRC + 1);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [WIDTH-1:0]      prog_data;
    logic                  xfer_req;
    logic [SW-1:0]         xfer_src;
    logic [NDST-1:0]       xfer_dst;
    logic                  HLT;
    logic [WIDTH-1:0]      bus_out;
    logic [NDST-1:0]       dst_we;
    logic                  xfer_ack;
    logic                  busy;
    logic                  xfer_err;
    logic [7:0]            err_cnt;

    modport master (
        output src_data, prog_data, xfer_req, xfer_src, xfer_dst, HLT,
        input  bus_out, dst_we, xfer_ack, busy, xfer_err, err_cnt
    );

    modport slave (
        input  src_data, prog_data, xfer_req, xfer_src, xfer_dst, HLT,
        output bus_out, dst_we, xfer_ack, busy, xfer_err, err_cnt
    );
endinterface

// File: rtl/bus_xfer_fabric.sv
// Registered SAP data-bus fabric: one source per 4-phase req/ack transfer, multi-hot load strobes.
// Optional feature: define BUS_DEBOUNCE_EN to synchronise and debounce xfer_req.
module bus_xfer_fabric #(
    parameter int WIDTH   = 8,
    parameter int NSRC    = 6,
    parameter int NDST    = 6,
    parameter int DB_BITS = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    bus_xfer_fabric_if.slave  bus
);
    localparam int SW = $clog2(NSRC + 1);
    localparam logic [SW-1:0] PROG_IDX = SW'(NSRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [SW-1:0]   src_r, src_nxt_s;
    logic [NDST-1:0] dst_r, dst_nxt_s;
    logic [NDST-1:0] dst_we_r, dst_we_nxt_s;
    logic [WIDTH-1:0] bus_r, bus_nxt_s, sel_data_s;
    logic            ack_r, ack_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            err_r, err_nxt_s;
    logic            bad_r, bad_nxt_s;
    logic [7:0]      err_cnt_r, err_cnt_nxt_s;
    logic            req_s;

`ifdef BUS_DEBOUNCE_EN
    logic [1:0]         sync_r;
    logic               sync_d_r;
    logic [DB_BITS-1:0] db_cnt_r;
    logic               req_db_r;

    // Two-flop synchroniser plus stability counter; req_s follows the input only once it has held.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_r   <= 2'b00;
            sync_d_r <= 1'b0;
            db_cnt_r <= {DB_BITS{1'b0}};
            req_db_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[0], bus.xfer_req};
            sync_d_r <= sync_r[1];
            if (sync_r[1] != sync_d_r) begin
                db_cnt_r <= {DB_BITS{1'b0}};
            end else if (db_cnt_r != {DB_BITS{1'b1}}) begin
                db_cnt_r <= db_cnt_r + DB_BITS'(1);
            end else begin
                db_cnt_r <= db_cnt_r;
            end
            if (db_cnt_r == {DB_BITS{1'b1}}) begin
                req_db_r <= sync_d_r;
            end else begin
                req_db_r <= req_db_r;
            end
        end
    end

    assign req_s = req_db_r;
`else
    logic unused_db_s;
    assign unused_db_s = (DB_BITS > 0);
    assign req_s       = bus.xfer_req;
`endif

    // Source mux; index NSRC (and any out-of-range index) falls through to the programmer data.
    always_comb begin
        sel_data_s = bus.prog_data;
        for (int i = 0; i < NSRC; i++) begin
            sel_data_s = (src_r == SW'(i)) ? bus.src_data[i*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        src_nxt_s     = src_r;
        dst_nxt_s     = dst_r;
        bus_nxt_s     = bus_r;
        dst_we_nxt_s  = {NDST{1'b0}};
        ack_nxt_s     = ack_r;
        err_nxt_s     = err_r;
        bad_nxt_s     = bad_r;
        err_cnt_nxt_s = err_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !bus.HLT) begin
                    state_nxt_s = ST_DRIVE;
                    src_nxt_s   = bus.xfer_src;
                    dst_nxt_s   = bus.xfer_dst;
                    bad_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_nxt_s = ST_WRITE;
                if (src_r > PROG_IDX) begin
                    bad_nxt_s     = 1'b1;
                    err_nxt_s     = 1'b1;
                    err_cnt_nxt_s = (err_cnt_r == 8'hFF) ? 8'hFF : err_cnt_r + 8'd1;
                end else begin
                    bad_nxt_s = 1'b0;
                    bus_nxt_s = sel_data_s;
                end
            end
            ST_WRITE: begin
                state_nxt_s  = ST_DONE;
                dst_we_nxt_s = bad_r ? {NDST{1'b0}} : dst_r;
                ack_nxt_s    = 1'b1;
            end
            ST_DONE: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                    ack_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ack_nxt_s   = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers; reset clears everything, including the sticky error.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            src_r     <= {SW{1'b0}};
            dst_r     <= {NDST{1'b0}};
            bus_r     <= {WIDTH{1'b0}};
            dst_we_r  <= {NDST{1'b0}};
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            bad_r     <= 1'b0;
            err_cnt_r <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            src_r     <= src_nxt_s;
            dst_r     <= dst_nxt_s;
            bus_r     <= bus_nxt_s;
            dst_we_r  <= dst_we_nxt_s;
            ack_r     <= ack_nxt_s;
            busy_r    <= busy_nxt_s;
            err_r     <= err_nxt_s;
            bad_r     <= bad_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign bus.bus_out  = bus_r;
    assign bus.dst_we   = dst_we_r;
    assign bus.xfer_ack = ack_r;
    assign bus.busy     = busy_r;
    assign bus.xfer_err = err_r;
    assign bus.err_cnt  = err_cnt_r;
endmodule
